// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use interlock (bubble insertion + front-end freeze).
// Define ID_EX_PERF_CNT_EN to add saturating bubble/flush performance counters.
module id_ex_stage #(
    parameter int XLEN     = 32,
    parameter int KEY_W    = 5,
    parameter int ALU_OP_W = 4,
    parameter int LOAD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [KEY_W-1:0]    id_src1_key,
    input  logic [KEY_W-1:0]    id_src2_key,
    input  logic                id_src1_used,
    input  logic                id_src2_used,
    input  logic [XLEN-1:0]     id_src1_val,
    input  logic [XLEN-1:0]     id_src2_val,
    input  logic [XLEN-1:0]     id_imm,
    input  logic [KEY_W-1:0]    id_rd_key,
    input  logic                id_rd_en,
    input  logic                id_is_load,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_use_imm,
    input  logic                flush,
    input  logic                mem_busy,
    output logic                ex_valid,
    output logic [KEY_W-1:0]    ex_src1_key,
    output logic [KEY_W-1:0]    ex_src2_key,
    output logic [XLEN-1:0]     ex_src1_val,
    output logic [XLEN-1:0]     ex_src2_val,
    output logic [XLEN-1:0]     ex_imm,
    output logic [KEY_W-1:0]    ex_rd_key,
    output logic                ex_rd_en,
    output logic                ex_is_load,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_use_imm,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]         perf_bubble_cnt,
    output logic [31:0]         perf_flush_cnt,
`endif
    output logic                id_stall
);
    typedef enum logic {RUN, STALL} state_t;
    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       hz, bubble, advance, stall_c;
    assign hz = ex_valid & ex_is_load & ex_rd_en & (ex_rd_key != '0) & id_valid &
                ((id_src1_used & (id_src1_key == ex_rd_key)) | (id_src2_used & (id_src2_key == ex_rd_key)));
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bubble  = 1'b0;
        advance = 1'b0;
        stall_c = 1'b0;
        if (flush) begin
            bubble  = 1'b1;
            state_n = RUN;
            cnt_n   = '0;
        end else if (mem_busy) begin
            stall_c = 1'b1;
        end else if (state == STALL) begin
            bubble  = 1'b1;
            stall_c = 1'b1;
            state_n = (cnt == 3'd1) ? RUN : STALL;
            cnt_n   = cnt - 3'd1;
        end else if (hz) begin
            bubble  = 1'b1;
            stall_c = 1'b1;
            state_n = (LOAD_LAT > 1) ? STALL : RUN;
            cnt_n   = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 1) : '0;
        end else begin
            advance = 1'b1;
        end
    end
    // Reset redirects the front end, so it must never see a freeze while reset is high
    assign id_stall = stall_c & ~reset;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_src1_key <= '0;
            ex_src2_key <= '0;
            ex_src1_val <= '0;
            ex_src2_val <= '0;
            ex_imm      <= '0;
            ex_rd_key   <= '0;
            ex_rd_en    <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_alu_op   <= '0;
            ex_use_imm  <= 1'b0;
        end else if (advance) begin
            ex_valid    <= id_valid;
            ex_src1_key <= id_src1_key;
            ex_src2_key <= id_src2_key;
            ex_src1_val <= id_src1_val;
            ex_src2_val <= id_src2_val;
            ex_imm      <= id_imm;
            ex_rd_key   <= id_rd_key;
            ex_rd_en    <= id_rd_en & id_valid;
            ex_is_load  <= id_is_load & id_valid;
            ex_alu_op   <= id_alu_op;
            ex_use_imm  <= id_use_imm;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_rd_en    <= 1'b0;
            ex_is_load  <= 1'b0;
        end
    end
`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (bubble & ~flush & (perf_bubble_cnt != '1))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (flush & (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized scoreboard bench for id_ex_stage, run at LOAD_LAT=1 and LOAD_LAT=3.
// Define ID_EX_PERF_CNT_EN to also check the performance counters.
module tb_id_ex_stage;
    typedef struct packed {
        logic v; logic [4:0] s1k, s2k; logic [31:0] s1v, s2v, imm;
        logic [4:0] rdk; logic rde, ld; logic [3:0] op; logic ui;
    } ex_t;
    typedef struct packed {
        logic v; logic [4:0] s1k, s2k; logic s1u, s2u; logic [31:0] s1v, s2v, imm;
        logic [4:0] rdk; logic rde, ld; logic [3:0] op; logic ui;
    } id_t;
    typedef struct packed { ex_t ex; logic st; logic [31:0] pb, pf; } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;
        logic rst, flush, busy, stall, fin;
        id_t id;
        ex_t act;
        logic ex_valid, ex_rd_en, ex_is_load, ex_use_imm;
        logic [4:0] ex_src1_key, ex_src2_key, ex_rd_key;
        logic [31:0] ex_src1_val, ex_src2_val, ex_imm, pb, pf;
        logic [3:0] ex_alu_op;
        exp_t q[$];
        exp_t e;
        ex_t m_ex, last;
        int since;
        logic [31:0] mpb, mpf;
        logic st_exp;

        id_ex_stage #(.LOAD_LAT(LAT)) dut (
            .clk(clk), .reset(rst), .id_valid(id.v),
            .id_src1_key(id.s1k), .id_src2_key(id.s2k),
            .id_src1_used(id.s1u), .id_src2_used(id.s2u),
            .id_src1_val(id.s1v), .id_src2_val(id.s2v), .id_imm(id.imm),
            .id_rd_key(id.rdk), .id_rd_en(id.rde), .id_is_load(id.ld),
            .id_alu_op(id.op), .id_use_imm(id.ui),
            .flush(flush), .mem_busy(busy),
            .ex_valid(ex_valid), .ex_src1_key(ex_src1_key), .ex_src2_key(ex_src2_key),
            .ex_src1_val(ex_src1_val), .ex_src2_val(ex_src2_val), .ex_imm(ex_imm),
            .ex_rd_key(ex_rd_key), .ex_rd_en(ex_rd_en), .ex_is_load(ex_is_load),
            .ex_alu_op(ex_alu_op), .ex_use_imm(ex_use_imm),
`ifdef ID_EX_PERF_CNT_EN
            .perf_bubble_cnt(pb), .perf_flush_cnt(pf),
`endif
            .id_stall(stall)
        );
`ifndef ID_EX_PERF_CNT_EN
        assign pb = '0;
        assign pf = '0;
`endif
        assign act = {ex_valid, ex_src1_key, ex_src2_key, ex_src1_val, ex_src2_val, ex_imm,
                      ex_rd_key, ex_rd_en, ex_is_load, ex_alu_op, ex_use_imm};

        function automatic ex_t cap(id_t i);
            return {i.v, i.s1k, i.s2k, i.s1v, i.s2v, i.imm, i.rdk, i.rde & i.v, i.ld & i.v, i.op, i.ui};
        endfunction

        // The consumer in ID depends on the most recent instruction that entered EX, if it was a load
        function automatic logic dep();
            return last.v && last.ld && last.rde && last.rdk != 5'd0 && id.v &&
                   ((id.s1u && id.s1k == last.rdk) || (id.s2u && id.s2k == last.rdk));
        endfunction

        function automatic id_t rnd_id();
            id_t i;
            i.v   = $urandom_range(9) != 0;
            i.s1k = 5'($urandom_range(3));
            i.s2k = 5'($urandom_range(3));
            i.s1u = $urandom_range(3) != 0;
            i.s2u = $urandom_range(3) != 0;
            i.s1v = $urandom;
            i.s2v = $urandom;
            i.imm = $urandom;
            i.rdk = 5'($urandom_range(3));
            i.rde = $urandom_range(4) != 0;
            i.ld  = $urandom_range(1) != 0;
            i.op  = 4'($urandom_range(15));
            i.ui  = $urandom_range(1) != 0;
            return i;
        endfunction

        task automatic clear();
            m_ex = '0;
            last = '0;
            since = 0;
            mpb = 0;
            mpf = 0;
        endtask

        // Effect of one clock edge given the inputs held across it
        task automatic step();
            if (rst) clear();
            else if (flush) begin
                m_ex.v = 1'b0;
                m_ex.rde = 1'b0;
                m_ex.ld = 1'b0;
                last = '0;
                since = 0;
                mpf = mpf + 1;
            end else if (busy) begin
            end else if (dep() && since < LAT) begin
                m_ex.v = 1'b0;
                m_ex.rde = 1'b0;
                m_ex.ld = 1'b0;
                since = since + 1;
                mpb = mpb + 1;
            end else begin
                m_ex = cap(id);
                last = m_ex;
                since = 0;
            end
        endtask

        initial begin
            fin = 1'b0;
            rst = 1'b1;
            flush = 1'b0;
            busy = 1'b0;
            id = '0;
            st_exp = 1'b0;
            clear();
            for (int k = 0; k < 3000; k++) begin
                @(posedge clk);
                step();
                #1;
                rst = (k < 3) || ($urandom_range(99) < 2);
                flush = $urandom_range(99) < 5;
                busy = $urandom_range(99) < 15;
                if (!st_exp) id = rnd_id();
                if (rst) clear();
                st_exp = !rst && !flush && (busy || (dep() && since < LAT));
                q.push_back({m_ex, st_exp, mpb, mpf});
            end
            @(negedge clk);
            #1;
            fin = 1'b1;
        end

        always @(negedge clk) begin
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (act !== e.ex) begin
                    failures++;
                    $display("FAIL lat%0d ex_regs t=%0t got=%h want=%h", LAT, $time, act, e.ex);
                end
                checks++;
                if (stall !== e.st) begin
                    failures++;
                    $display("FAIL lat%0d id_stall t=%0t got=%b want=%b", LAT, $time, stall, e.st);
                end
`ifdef ID_EX_PERF_CNT_EN
                checks++;
                if (pb !== e.pb || pf !== e.pf) begin
                    failures++;
                    $display("FAIL lat%0d perf t=%0t got=%0d/%0d want=%0d/%0d", LAT, $time, pb, pf, e.pb, e.pf);
                end
`endif
            end
        end
    end

    initial begin
        wait (lane[0].fin && lane[1].fin);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
